// File: rtl/mm_line_responder.sv
// Line-granular memory responder: 256-bit line writes, fixed-latency in-order
// line reads with bounded outstanding depth, and a registered error pulse.
module mm_line_responder #(
  parameter int MEM_RANGE = 256,
  parameter int LATENCY   = 4,
  parameter int DEPTH     = 2
) (
  input  logic         master_clk,
  input  logic         reset,
  input  logic [31:0]  a,
  input  logic [255:0] wd,
  input  logic         read,
  input  logic         write,
  output logic [255:0] rd,
  output logic         valid,
  output logic         busy,
  output logic         err
);

  localparam int AW = (MEM_RANGE > 1) ? $clog2(MEM_RANGE) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [255:0]        mem [MEM_RANGE];
  // Lines never written return their power-up pattern instead of RAM contents.
  logic [MEM_RANGE-1:0] line_written = '0;

  logic [255:0]        fifo_data [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [LATENCY-1:0]  tag_q, tag_d;
  logic                err_q, err_d;

  logic [26:0]         line_idx;
  logic [AW-1:0]       mem_addr;
  logic                in_range;
  logic                do_read;
  logic                do_write;
  logic                pop;
  logic [255:0]        init_line;
  logic [255:0]        sample_data;
  logic                unused_addr_bits;

  assign line_idx         = a[31:5];
  assign mem_addr         = line_idx[AW-1:0];
  assign in_range         = (line_idx < 27'(MEM_RANGE));
  assign unused_addr_bits = ^a[4:0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_init_word
      assign init_line[32*gi +: 32] = {2'b00, line_idx, 3'(gi)};
    end
  endgenerate

  assign busy  = (count_q == CW'(DEPTH));
  assign valid = tag_q[LATENCY-1];
  assign pop   = tag_q[LATENCY-1];
  assign rd    = valid ? fifo_data[rd_ptr_q] : '0;
  assign err   = err_q;

  always_comb begin
    do_write = !reset && write && !read && in_range;
    do_read  = !reset && read && !write && !busy;
    err_d    = !reset && ((read && write) ||
                          (write && !read && !in_range) ||
                          (read && !write && busy) ||
                          (read && !write && !busy && !in_range));

    if (!in_range)
      sample_data = '0;
    else if (line_written[mem_addr])
      sample_data = mem[mem_addr];
    else
      sample_data = init_line;

    tag_d    = LATENCY'({tag_q, do_read});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_read)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({do_read, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (reset) begin
      tag_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge master_clk) begin
    tag_q    <= tag_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    err_q    <= err_d;
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge master_clk) begin
    if (do_write) begin
      mem[mem_addr]          <= wd;
      line_written[mem_addr] <= 1'b1;
    end
  end

  always_ff @(posedge master_clk) begin
    if (do_read)
      fifo_data[wr_ptr_q] <= sample_data;
  end

endmodule
